// File: rtl/nn_image_streamer_pkg.sv
// Shared constants and FSM encodings for the image streamer.
// Kept in one place so the top level and the bench agree on the defaults.
package nn_image_streamer_pkg;

  localparam int NN_SAMPLE_WIDTH  = 16;
  localparam int NN_IMAGE_SAMPLES = 784;

  typedef logic [1:0] nn_state_t;

  localparam nn_state_t ST_IDLE   = 2'd0;
  localparam nn_state_t ST_STREAM = 2'd1;
  localparam nn_state_t ST_FINISH = 2'd2;

endpackage

// File: rtl/nn_sample_ram.sv
// Image sample buffer: one write port and one synchronous read port with 1-cycle latency.
// There is no reset, so synthesis can map it onto block RAM.
module nn_sample_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/nn_image_streamer.sv
// AXI-Stream source that streams one buffered image into the inference core.
// The top level holds the FSM, the read pointer, the two-entry output stage and the write-error logic.
module nn_image_streamer
  import nn_image_streamer_pkg::*;
#(
  parameter int NUM_SAMPLES = NN_IMAGE_SAMPLES,
  parameter int DATA_WIDTH  = NN_SAMPLE_WIDTH,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] axis_out_data,
  output logic                  axis_out_data_valid,
  input  logic                  axis_out_data_ready,
  output logic                  axis_out_data_last
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] NUM_P    = PTR_W'(NUM_SAMPLES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SAMPLES - 1);

  nn_state_t             state;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_en;
  logic                  rd_pending;
  logic                  rd_pending_last;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_last;
  logic                  wr_ok;
  logic                  pop;
  logic [1:0]            held;
  logic [1:0]            in_use;

  assign wr_ok = (state == ST_IDLE) && ({1'b0, wr_addr} < NUM_P);
  assign pop   = axis_out_data_valid && axis_out_data_ready;
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_FINISH);

  // Occupancy counts this cycle's pop so the stage can refill every cycle without a bubble.
  always_comb begin
    held   = 2'(axis_out_data_valid) + 2'(skid_valid);
    in_use = held + 2'(rd_pending) - 2'(pop);
    rd_en  = (state == ST_STREAM) && (rd_ptr < NUM_P) && (in_use < 2'd2);
  end

  nn_sample_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (s_axi_aclk),
    .we    (wr_en && wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state  <= ST_IDLE;
      rd_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_STREAM;
            rd_ptr <= '0;
          end
        end
        ST_STREAM: begin
          if (rd_en) rd_ptr <= rd_ptr + 1'b1;
          if (pop && axis_out_data_last) state <= ST_FINISH;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // The last flag travels with the read so it stays attached to its sample through the skid stage.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
      wr_err          <= 1'b0;
    end else begin
      rd_pending      <= rd_en;
      rd_pending_last <= (rd_ptr == LAST_IDX);
      wr_err          <= wr_en && !wr_ok;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      axis_out_data_valid <= 1'b0;
      axis_out_data       <= '0;
      axis_out_data_last  <= 1'b0;
      skid_valid          <= 1'b0;
      skid_data           <= '0;
      skid_last           <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        axis_out_data      <= skid_data;
        axis_out_data_last <= skid_last;
        skid_valid         <= rd_pending;
        if (rd_pending) begin
          skid_data <= ram_q;
          skid_last <= rd_pending_last;
        end
      end else begin
        axis_out_data_valid <= rd_pending;
        if (rd_pending) begin
          axis_out_data      <= ram_q;
          axis_out_data_last <= rd_pending_last;
        end
      end
    end else if (rd_pending) begin
      if (!axis_out_data_valid) begin
        axis_out_data_valid <= 1'b1;
        axis_out_data       <= ram_q;
        axis_out_data_last  <= rd_pending_last;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= ram_q;
        skid_last  <= rd_pending_last;
      end
    end
  end

endmodule

// File: tb/tb_nn_image_streamer.sv
// Self-checking bench: a 784-sample instance against an array/queue reference model,
// plus a 4-sample instance for the back-to-back small-image case.
module tb_nn_image_streamer;

  localparam int N   = 784;
  localparam int AW  = 10;
  localparam int SN  = 4;
  localparam int SAW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          wr_err;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [15:0]   dout;
  logic          valid;
  logic          ready = 1'b1;
  logic          last;

  logic           s_wr_en = 1'b0;
  logic [SAW-1:0] s_wr_addr = '0;
  logic [15:0]    s_wr_data = '0;
  logic           s_wr_err;
  logic           s_start = 1'b0;
  logic           s_busy;
  logic           s_done;
  logic [15:0]    s_dout;
  logic           s_valid;
  logic           s_ready = 1'b1;
  logic           s_last;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] model_mem [N];
  logic [15:0] small_mem [SN];
  int beat = 0;
  int first_valid_rel = -1;
  int last_hs_rel = -1;
  int done_rel = -1;
  int done_cnt = 0;
  int start_cyc = 0;
  bit in_stream = 1'b0;
  int ready_mode = 1;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic prev_last = 1'b0;

  logic [15:0] s_data_q[$];
  logic        s_last_q[$];
  int s_done_cnt = 0;

  nn_image_streamer #(.NUM_SAMPLES(N), .DATA_WIDTH(16), .ADDR_WIDTH(AW)) dut (
    .s_axi_aclk          (clk),
    .s_axi_aresetn       (rst_n),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_err              (wr_err),
    .start               (start),
    .busy                (busy),
    .done                (done),
    .axis_out_data       (dout),
    .axis_out_data_valid (valid),
    .axis_out_data_ready (ready),
    .axis_out_data_last  (last)
  );

  nn_image_streamer #(.NUM_SAMPLES(SN), .DATA_WIDTH(16), .ADDR_WIDTH(SAW)) dut_small (
    .s_axi_aclk          (clk),
    .s_axi_aresetn       (rst_n),
    .wr_en               (s_wr_en),
    .wr_addr             (s_wr_addr),
    .wr_data             (s_wr_data),
    .wr_err              (s_wr_err),
    .start               (s_start),
    .busy                (s_busy),
    .done                (s_done),
    .axis_out_data       (s_dout),
    .axis_out_data_valid (s_valid),
    .axis_out_data_ready (s_ready),
    .axis_out_data_last  (s_last)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Ready pattern: 0 = held low, 1 = held high, 2 = random 50%.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready = 1'b0;
      2:       ready = 1'($urandom_range(1));
      default: ready = 1'b1;
    endcase
  end

  // Stream monitor for the large instance: every handshake is checked against the model.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(valid), 32'd1);
        checkOutput("hold_data", 32'(dout), 32'(prev_data));
        checkOutput("hold_last", 32'(last), 32'(prev_last));
      end
      if (in_stream && valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
      if (valid && ready) begin
        if (beat < N) checkOutput("beat_data", 32'(dout), 32'(model_mem[beat]));
        else checkOutput("extra_beat", 32'(beat), 32'(N - 1));
        checkOutput("beat_last", 32'(last), 32'(beat == N - 1));
        if (last) last_hs_rel = cyc - start_cyc;
        beat++;
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - start_cyc;
      end
      prev_stall = valid && !ready;
      prev_data  = dout;
      prev_last  = last;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (s_valid && s_ready) begin
        s_data_q.push_back(s_dout);
        s_last_q.push_back(s_last);
      end
      if (s_done) s_done_cnt++;
    end
  end

  task automatic applyStimulus(input int addr, input logic [15:0] data);
    bit ok;
    ok = !in_stream && (addr < N);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (ok) model_mem[addr] = data;
    @(negedge clk);
    checkOutput("wr_err", 32'(wr_err), 32'(!ok));
  endtask

  task automatic smallWrite(input int addr, input logic [15:0] data);
    bit ok;
    ok = (addr < SN);
    @(posedge clk); #1;
    s_wr_en = 1'b1; s_wr_addr = SAW'(addr); s_wr_data = data;
    @(posedge clk); #1;
    s_wr_en = 1'b0;
    if (ok) small_mem[addr] = data;
    @(negedge clk);
    checkOutput("s_wr_err", 32'(s_wr_err), 32'(!ok));
  endtask

  task automatic startStream();
    @(posedge clk); #1;
    start = 1'b1;
    beat = 0; first_valid_rel = -1; last_hs_rel = -1; done_rel = -1;
    in_stream = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic waitDone(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
    checkOutput("busy_in_finish", 32'(busy), 32'd1);
    checkOutput("beat_count", 32'(beat), 32'(N));
    @(negedge clk);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    in_stream = 1'b0;
  endtask

  task automatic checkTiming(input string tag);
    checkOutput({tag, "_first_valid"}, 32'(first_valid_rel), 32'd2);
    checkOutput({tag, "_last_beat"}, 32'(last_hs_rel), 32'(N + 1));
    checkOutput({tag, "_done_at"}, 32'(done_rel), 32'(N + 2));
  endtask

  initial begin
    int done_before;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_last", 32'(last), 32'd0);
    checkOutput("rst_data", 32'(dout), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr_err", 32'(wr_err), 32'd0);
    checkOutput("rst_s_valid", 32'(s_valid), 32'd0);
    checkOutput("rst_s_busy", 32'(s_busy), 32'd0);
    rst_n = 1'b1;

    // Ramp with ready held high
    for (int i = 0; i < N; i++) applyStimulus(i, 16'(i));
    ready_mode = 1;
    startStream();
    waitDone(N + 20);
    checkTiming("ramp");

    // Early stall: ready low for the first 10 cycles
    ready_mode = 0;
    repeat (3) @(posedge clk);
    startStream();
    repeat (10) @(negedge clk);
    checkOutput("stall_valid", 32'(valid), 32'd1);
    checkOutput("stall_data", 32'(dout), 32'(model_mem[0]));
    checkOutput("stall_no_beats", 32'(beat), 32'd0);
    ready_mode = 1;
    waitDone(N + 40);

    // Illegal writes: one while busy, one out of range in IDLE, then re-stream
    startStream();
    repeat (20) @(posedge clk);
    applyStimulus(5, 16'hFFFF);
    waitDone(N + 20);
    applyStimulus(800, 16'h1234);
    startStream();
    waitDone(N + 20);
    checkTiming("restream");

    // Random contents (including out-of-range addresses) under random backpressure
    repeat (60) applyStimulus(int'($urandom_range(1023)), 16'($urandom));
    ready_mode = 2;
    startStream();
    waitDone(N * 8);
    ready_mode = 1;

    // Reset abort at beat 100
    startStream();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (beat >= 100) break;
    end
    checkOutput("abort_reached", 32'(beat >= 100), 32'd1);
    #1;
    rst_n = 1'b0;
    done_before = done_cnt;
    #1;
    checkOutput("abort_valid", 32'(valid), 32'd0);
    checkOutput("abort_last", 32'(last), 32'd0);
    checkOutput("abort_data", 32'(dout), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_stream = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_cnt), 32'(done_before));
    startStream();
    waitDone(N + 20);
    checkTiming("after_abort");

    // Small image, second start in the first IDLE cycle
    for (int i = 0; i < SN; i++) smallWrite(i, 16'($urandom));
    smallWrite(6, 16'hBEEF);
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_done) break;
    end
    checkOutput("s_first_done", 32'(s_done), 32'd1);
    @(posedge clk); #1;
    checkOutput("s_idle_gap", 32'(s_busy), 32'd0);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    checkOutput("s_b2b_accepted", 32'(s_busy), 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("s_beats", 32'(s_data_q.size()), 32'(2 * SN));
    checkOutput("s_done_pulses", 32'(s_done_cnt), 32'd2);
    for (int i = 0; i < s_data_q.size() && i < 2 * SN; i++) begin
      checkOutput("s_data", 32'(s_data_q[i]), 32'(small_mem[i % SN]));
      checkOutput("s_last", 32'(s_last_q[i]), 32'((i % SN) == SN - 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_image_streamer.md
# nn_image_streamer

Transmit-side AXI-Stream source for the inference core. It holds one input image of `NUM_SAMPLES` 16-bit samples in a local buffer, filled through a simple write port by the host/DMA side. On `start` it streams the samples in address order onto a valid/ready stream that connects directly to the core's `axis_in_data*` input. It honours backpressure at full throughput, flags the final beat, and signals completion.

## Interface
Parameters:
- `NUM_SAMPLES`, 784, samples per image (first-layer `numWeight`).
- `DATA_WIDTH`, 16, sample width in bits.
- `ADDR_WIDTH`, 10, buffer address width; must satisfy 2^ADDR_WIDTH >= NUM_SAMPLES.

Ports:
- `s_axi_aclk` in 1: single clock.
- `s_axi_aresetn` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in ADDR_WIDTH: write address.
- `wr_data` in DATA_WIDTH: write data.
- `wr_err` out 1: one-cycle pulse when a write is rejected.
- `start` in 1: begin streaming, sampled on the clock edge.
- `busy` out 1: high while an image is being streamed.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `axis_out_data` out DATA_WIDTH: stream data.
- `axis_out_data_valid` out 1: stream valid.
- `axis_out_data_ready` in 1: stream ready.
- `axis_out_data_last` out 1: high on beat NUM_SAMPLES-1.

## Operation
- Reset values:
  - `busy`, `done`, `wr_err`, `axis_out_data_valid` and `axis_out_data_last` are 0.
  - `axis_out_data` is 0.
  - The FSM is in IDLE and the pointers are 0.
  - Buffer contents are not reset.
- FSM states: IDLE, STREAM, FINISH.
  - IDLE → STREAM when `start` is high.
  - STREAM → FINISH on the handshake (`axis_out_data_valid && axis_out_data_ready`) of the beat that has `axis_out_data_last` set.
  - FINISH → IDLE unconditionally. `done` pulses during FINISH.
- Writes:
  - Accepted only in IDLE with `wr_addr < NUM_SAMPLES`.
  - Otherwise the write is dropped, the buffer is unchanged, and `wr_err` pulses the next cycle.
  - A write in the same cycle as `start` is accepted and is visible to the stream.
- `start` outside IDLE is ignored.
- Read path:
  - `rd_ptr` counts 0..NUM_SAMPLES-1. The buffer has synchronous read with 1-cycle latency.
  - A two-entry output stage (output register plus skid register) sits after the buffer.
  - A read is issued whenever (entries held + reads in flight) < 2 and `rd_ptr` < NUM_SAMPLES.
  - The entry counter never exceeds 2, and no sample is dropped or duplicated.
- AXI-Stream rules:
  - Once `axis_out_data_valid` is high, it stays high with `axis_out_data` and `axis_out_data_last` stable until the handshake.
  - Valid does not depend combinationally on ready.
- Beat counter: `axis_out_data_last` is asserted exactly when the presented sample is index NUM_SAMPLES-1.
- Reset mid-stream:
  - Outputs return to their reset values immediately.
  - The stream aborts with no `done` pulse.
  - A subsequent `start` streams from index 0.

## Timing
Let `start` be sampled at edge T.
- `busy` is 1 from T+1 through the FINISH cycle.
- First read is issued at T+1.
- `axis_out_data_valid` is first high at T+2 with sample 0.
- With ready held high:
  - One beat is transferred per cycle.
  - The last beat is at T+1+NUM_SAMPLES.
  - FINISH/`done` follows at T+2+NUM_SAMPLES.
  - `busy` is 0 from T+3+NUM_SAMPLES.
- A back-to-back `start` is accepted in the first IDLE cycle.
- When ready deasserts for N cycles, valid stays high and the data is frozen.
- When ready reasserts, the stream resumes at one beat per cycle with no bubble.

## Structure
- Shared package/include holds:
  - `NN_SAMPLE_WIDTH`=16
  - `NN_IMAGE_SAMPLES`=784
  - FSM state encodings
- Sub-module `nn_sample_ram`:
  - Simple dual-port memory with one write port and one synchronous read port.
  - Infers BRAM, no reset.
- Top level holds the FSM, pointers, skid stage and error logic.

## Test plan
- Ramp, ready=1:
  - Stimulus: load `mem[i]=i` for i=0..783, then pulse `start`.
  - Response: 784 consecutive beats with data 0..783; `last` only on data 783; `done` at T+786.
- Random backpressure:
  - Stimulus: ramp as above, ready random at 50%.
  - Response: exactly 784 handshakes with data 0..783 in order; data and `last` stable during every stall.
- Early stall:
  - Stimulus: ramp loaded, ready=0 for 10 cycles after `start`.
  - Response: valid high with data 0 and held; stream completes normally once ready rises.
- Illegal writes:
  - Stimulus: write `addr=5, data=0xFFFF` while busy; write `addr=800` in IDLE.
  - Response: `wr_err` pulses twice; a re-stream shows `mem[5]=5`.
- Reset abort:
  - Stimulus: assert reset at beat 100.
  - Response: valid=0 immediately and no `done`; after release and `start`, beats 0..783 are output again.
- Small-image regression:
  - Stimulus: `NUM_SAMPLES=4`, data {A,B,C,D}, `start` reasserted in the first IDLE cycle.
  - Response: two full streams A,B,C,D; `last` on each D; two `done` pulses.
